// File: rtl/fme_distortion_accum.sv
// Row-serial SAD accumulator for the nine FME sub-pel candidates of one block.
// Emits a packed 9-entry distortion vector with a single-cycle done pulse.
module fme_distortion_accum #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned BLK    = 4,
  parameter int unsigned DIST_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BLK*PIX_W-1:0]         cur_row,
  input  logic [BLK*PIX_W-1:0]         ref_row,
  output logic [3:0]                   cand_idx,
  output logic [((BLK > 1) ? $clog2(BLK) : 1)-1:0] row_idx,
  output logic                         busy,
  output logic                         done,
  output logic [8:0][DIST_W-1:0]       distort
);

  localparam int unsigned RIDX_W = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int unsigned RSAD_W = PIX_W + $clog2(BLK);
  localparam int unsigned SUM_W  = ((DIST_W > RSAD_W) ? DIST_W : RSAD_W) + 1;
  localparam logic [DIST_W-1:0] DIST_MAX  = '1;
  localparam logic [3:0]        LAST_CAND = 4'd8;
  localparam logic [RIDX_W-1:0] LAST_ROW  = RIDX_W'(BLK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t              state;
  logic [DIST_W-1:0]   acc;
  logic [RSAD_W-1:0]   row_sad_c;
  logic [SUM_W-1:0]    sum_full_c;
  logic [DIST_W-1:0]   acc_next_c;
  logic [PIX_W-1:0]    pix_a_c;
  logic [PIX_W-1:0]    pix_b_c;
  logic [PIX_W-1:0]    pix_d_c;

  // Full-width row SAD; each absolute difference fits in PIX_W bits.
  always_comb begin
    row_sad_c = '0;
    pix_a_c   = '0;
    pix_b_c   = '0;
    pix_d_c   = '0;
    for (int k = 0; k < int'(BLK); k++) begin
      pix_a_c   = cur_row[k*PIX_W +: PIX_W];
      pix_b_c   = ref_row[k*PIX_W +: PIX_W];
      pix_d_c   = (pix_a_c >= pix_b_c) ? (pix_a_c - pix_b_c) : (pix_b_c - pix_a_c);
      row_sad_c = row_sad_c + RSAD_W'(pix_d_c);
    end
  end

  // Saturating accumulate; one extra bit catches the overflow.
  always_comb begin
    sum_full_c = SUM_W'(acc) + SUM_W'(row_sad_c);
    acc_next_c = (sum_full_c > SUM_W'(DIST_MAX)) ? DIST_MAX : DIST_W'(sum_full_c);
  end

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cand_idx <= '0;
      row_idx  <= '0;
      acc      <= '0;
      distort  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            acc      <= '0;
            cand_idx <= '0;
            row_idx  <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (row_idx == LAST_ROW) begin
              distort[cand_idx] <= acc_next_c;
              acc               <= '0;
              row_idx           <= '0;
              if (cand_idx == LAST_CAND) begin
                state    <= S_DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                cand_idx <= cand_idx + 4'd1;
              end
            end else begin
              acc     <= acc_next_c;
              row_idx <= row_idx + RIDX_W'(1);
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
